// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C codec register-write engine among N_REQ requesters,
// with retry on NACK/timeout and per-requester done/error reporting.
module i2c_cmd_arbiter #(
    parameter int unsigned N_REQ     = 3,
    parameter logic [7:0]  DEV_ADDR  = 8'h34,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*7-1:0] i_reg_addr,
    input  logic [N_REQ*9-1:0] i_reg_data,
    output logic [N_REQ-1:0]   o_grant,
    output logic [N_REQ-1:0]   o_done,
    output logic [N_REQ-1:0]   o_err,
    output logic               o_busy,
    output logic               o_eng_start,
    output logic [23:0]        o_eng_frame,
    input  logic               i_eng_busy,
    input  logic               i_eng_done,
    input  logic               i_eng_ack_err
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [23:0]   frame_q, frame_d;

    logic [2*N_REQ-1:0] req_dbl_c;
    logic [N_REQ-1:0]   req_rot_c;
    logic [N_REQ-1:0]   scan_c;
    logic               found_c;
    logic [PW-1:0]      off_c;
    logic [SW-1:0]      sum_c;
    logic [PW-1:0]      win_c;
    logic [6:0]         sel_addr_c;
    logic [8:0]         sel_data_c;
    logic [PW-1:0]      ptr_next_c;
    logic [N_REQ-1:0]   owner_oh_c;

    logic [N_REQ-1:0]   grant_c;
    logic [N_REQ-1:0]   done_c;
    logic [N_REQ-1:0]   err_c;
    logic               start_c;
    logic               fail_c;

    // Round-robin winner: rotate requests so ptr sits at bit 0, take the first set bit.
    always_comb begin
        req_dbl_c = {i_req, i_req};
        req_rot_c = N_REQ'(req_dbl_c >> ptr_q);
        scan_c    = req_rot_c;
        found_c   = 1'b0;
        off_c     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_c && scan_c[0]) begin
                found_c = 1'b1;
                off_c   = PW'(i);
            end
            scan_c = scan_c >> 1;
        end
        sum_c      = {1'b0, ptr_q} + {1'b0, off_c};
        win_c      = (sum_c >= SW'(N_REQ)) ? PW'(sum_c - SW'(N_REQ)) : PW'(sum_c);
        sel_addr_c = 7'(i_reg_addr >> (7 * win_c));
        sel_data_c = 9'(i_reg_data >> (9 * win_c));
        ptr_next_c = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
        owner_oh_c = N_REQ'(1) << owner_q;
    end

    // Next-state and pulse outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        retry_d = retry_q;
        timer_d = timer_q;
        frame_d = frame_q;
        grant_c = '0;
        done_c  = '0;
        err_c   = '0;
        start_c = 1'b0;
        fail_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    grant_c = N_REQ'(1) << win_c;
                    frame_d = {DEV_ADDR, sel_addr_c, sel_data_c};
                    owner_d = win_c;
                    retry_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!i_eng_busy) begin
                    start_c = 1'b1;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (i_eng_done) begin
                    if (!i_eng_ack_err) begin
                        done_c  = owner_oh_c;
                        ptr_d   = ptr_next_c;
                        state_d = ST_IDLE;
                    end else begin
                        fail_c = 1'b1;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    fail_c = 1'b1;
                end
                if (fail_c) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ST_ISSUE;
                    end else begin
                        err_c   = owner_oh_c;
                        ptr_d   = ptr_next_c;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            retry_q <= '0;
            timer_q <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
            frame_q <= frame_d;
        end
    end

    // Pulses are suppressed while reset is asserted so nothing is handed out that reset will discard.
    assign o_grant     = i_rst ? '0 : grant_c;
    assign o_done      = i_rst ? '0 : done_c;
    assign o_err       = i_rst ? '0 : err_c;
    assign o_eng_start = i_rst ? 1'b0 : start_c;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_eng_frame = frame_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters and engine.
module tb_i2c_cmd_arbiter;

    localparam int N  = 3;
    localparam int PW = 2;
    localparam int TO = 16;
    localparam int MR = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*7-1:0] ra;
    logic [N*9-1:0] rd;
    logic [N-1:0]   o_grant, o_done, o_err;
    logic           o_busy, o_eng_start;
    logic [23:0]    o_eng_frame;
    logic           eb, ed, ea;

    always #5 clk = ~clk;

    i2c_cmd_arbiter #(
        .N_REQ(N), .DEV_ADDR(8'h34), .MAX_RETRY(MR), .TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_reg_addr(ra), .i_reg_data(rd),
        .o_grant(o_grant), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
        .o_eng_start(o_eng_start), .o_eng_frame(o_eng_frame),
        .i_eng_busy(eb), .i_eng_done(ed), .i_eng_ack_err(ea)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: one granted transaction at a time, counted in attempts (starts) rather than retries.
    bit          m_act = 0;
    bit          m_inf = 0;
    int          m_owner = 0;
    int          m_ptr = 0;
    int          m_att = 0;
    int          m_age = 0;
    logic [23:0] m_frame = '0;

    logic [N-1:0] ev_grant = '0, last_err = '0;
    bit           ev_start = 0;
    int           n_start = 0, n_done = 0, n_err = 0, n_grant = 0;
    int           grant_log[$];
    int           start_cyc[$];
    int           err_cyc = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] eg, edn, ee;
        bit           es;
        int           w;
        cyc++;
        eg = '0; edn = '0; ee = '0; es = 0; w = -1;
        if (!rst) begin
            if (!m_act) begin
                for (int i = 0; i < N; i++)
                    if (w < 0 && req[PW'((m_ptr + i) % N)]) w = (m_ptr + i) % N;
                if (w >= 0) eg = N'(1) << w;
            end else if (!m_inf) begin
                es = !eb;
            end else if (ed && !ea) begin
                edn = N'(1) << m_owner;
            end else if ((ed || m_age == TO - 1) && m_att >= MR + 1) begin
                ee = N'(1) << m_owner;
            end
        end
        cmp("grant", 32'(o_grant), 32'(eg));
        cmp("start", 32'(o_eng_start), 32'(es));
        cmp("done", 32'(o_done), 32'(edn));
        cmp("err", 32'(o_err), 32'(ee));
        cmp("busy", 32'(o_busy), 32'(m_act));
        cmp("frame", 32'(o_eng_frame), 32'(m_frame));

        if (rst) begin
            m_act = 0; m_inf = 0; m_ptr = 0; m_frame = '0;
        end else if (!m_act) begin
            if (w >= 0) begin
                m_act = 1; m_inf = 0; m_owner = w; m_att = 0;
                m_frame = {8'h34, ra[7*w +: 7], rd[9*w +: 9]};
            end
        end else if (!m_inf) begin
            if (es) begin m_inf = 1; m_att++; m_age = 0; end
        end else if (|edn || |ee) begin
            m_act = 0; m_ptr = (m_owner + 1) % N;
        end else if (ed || m_age == TO - 1) begin
            m_inf = 0;
        end else begin
            m_age++;
        end

        ev_grant = o_grant;
        ev_start = o_eng_start;
        if (|o_grant) begin n_grant++; grant_log.push_back(int'(o_grant)); end
        if (o_eng_start) begin n_start++; start_cyc.push_back(cyc); end
        if (|o_done) n_done++;
        if (|o_err) begin n_err++; err_cyc = cyc; last_err = o_err; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        int k = 0;
        while (!ev_start && k < 60) begin tick(); k++; end
        if (k >= 60) cmp("start_timeout", 32'(ev_start), 32'(1));
    endtask

    // Serve one engine attempt: done after lat cycles in WAIT, with the given ACK result.
    task automatic attempt(input int lat, input bit nack);
        wait_start();
        repeat (lat) tick();
        ed = 1'b1; ea = nack;
        tick();
        ed = 1'b0; ea = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual=running expected=finished cycle=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int s0, g0, d0, e0, k, cd;
        bit nack;
        rst = 1'b1; req = '0; ra = '0; rd = '0; eb = 1'b0; ed = 1'b0; ea = 1'b0;
        tick(); tick();
        cmp("rst_busy", 32'(o_busy), 32'(0));
        cmp("rst_frame", 32'(o_eng_frame), 32'(0));
        rst = 1'b0;

        // Single request, idle engine.
        ra[6:0] = 7'h04; rd[8:0] = 9'h015; req = 3'b001;
        #1 cmp("t1_grant", 32'(o_grant), 32'h1);
        tick(); req = '0;
        #1 cmp("t1_start", 32'(o_eng_start), 32'h1);
        cmp("t1_frame", 32'(o_eng_frame), 32'h340815);
        tick(); ed = 1'b1; ea = 1'b0;
        #1 cmp("t1_done", 32'(o_done), 32'h1);
        tick(); ed = 1'b0;
        #1 cmp("t1_busy_fall", 32'(o_busy), 32'h0);

        // Round-robin with all requests held.
        pulse_reset();
        grant_log.delete();
        req = 3'b111;
        repeat (4) attempt(1, 1'b0);
        req = '0;
        tick();
        cmp("t2_ngrant", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() >= 4) begin
            cmp("t2_g0", 32'(grant_log[0]), 32'h1);
            cmp("t2_g1", 32'(grant_log[1]), 32'h2);
            cmp("t2_g2", 32'(grant_log[2]), 32'h4);
            cmp("t2_g3", 32'(grant_log[3]), 32'h1);
        end

        // Two NACKs then ACK.
        s0 = n_start; g0 = n_grant; d0 = n_done; e0 = n_err;
        ra[13:7] = 7'h7F; rd[17:9] = 9'h1AA; req = 3'b010;
        tick(); req = '0;
        attempt(0, 1'b1); attempt(2, 1'b1); attempt(1, 1'b0);
        cmp("t3_starts", 32'(n_start - s0), 32'd3);
        cmp("t3_grants", 32'(n_grant - g0), 32'd1);
        cmp("t3_dones", 32'(n_done - d0), 32'd1);
        cmp("t3_errs", 32'(n_err - e0), 32'd0);
        cmp("t3_frame", 32'(o_eng_frame), 32'h34FFAA);

        // Every attempt NACKs; the other pending requester follows.
        s0 = n_start; d0 = n_done; e0 = n_err;
        req = 3'b101;
        tick(); req = 3'b001;
        repeat (3) attempt(0, 1'b1);
        tick(); req = '0;
        cmp("t4_starts", 32'(n_start - s0), 32'd3);
        cmp("t4_errs", 32'(n_err - e0), 32'd1);
        cmp("t4_dones", 32'(n_done - d0), 32'd0);
        cmp("t4_err_owner", 32'(last_err), 32'h4);
        cmp("t4_next_grant", 32'(grant_log[$]), 32'h1);
        attempt(0, 1'b0);

        // Engine never answers.
        start_cyc.delete();
        e0 = n_err;
        req = 3'b010;
        tick(); req = '0;
        k = 0;
        while (n_err == e0 && k < 200) begin tick(); k++; end
        cmp("t5_err_seen", 32'(n_err - e0), 32'd1);
        cmp("t5_nstart", 32'(start_cyc.size()), 32'd3);
        if (start_cyc.size() >= 3) begin
            cmp("t5_retry1", 32'(start_cyc[1] - start_cyc[0]), 32'd17);
            cmp("t5_retry2", 32'(start_cyc[2] - start_cyc[0]), 32'd34);
            cmp("t5_err_at", 32'(err_cyc - start_cyc[0]), 32'd50);
        end
        // Done on the last timer cycle wins.
        req = 3'b100;
        tick(); req = '0;
        wait_start();
        repeat (TO - 1) tick();
        ed = 1'b1; ea = 1'b0;
        #1 cmp("t5_done_wins", 32'(o_done), 32'h4);
        cmp("t5_no_err", 32'(o_err), 32'h0);
        tick(); ed = 1'b0;

        // Busy engine holds ISSUE; reset mid-WAIT.
        eb = 1'b1; req = 3'b010;
        tick(); req = '0;
        repeat (5) begin
            #1 cmp("t6_hold_start", 32'(o_eng_start), 32'h0);
            cmp("t6_hold_busy", 32'(o_busy), 32'h1);
            tick();
        end
        eb = 1'b0;
        #1 cmp("t6_start", 32'(o_eng_start), 32'h1);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        #1 cmp("t6_rst_busy", 32'(o_busy), 32'h0);
        cmp("t6_rst_frame", 32'(o_eng_frame), 32'h0);
        cmp("t6_rst_pulses", 32'({o_done, o_err, o_eng_start}), 32'h0);
        rst = 1'b0; ed = 1'b1;
        tick(); ed = 1'b0; req = 3'b111;
        #1 cmp("t6_ptr0_grant", 32'(o_grant), 32'h1);
        tick(); req = '0;
        attempt(0, 1'b0);

        // Randomized requesters and engine.
        cd = -1; nack = 0;
        repeat (4000) begin
            tick();
            rst = ($urandom_range(0, 699) == 0);
            for (int j = 0; j < N; j++) begin
                if (req[j] && ev_grant[j]) req[j] = 1'b0;
                else if (!req[j] && $urandom_range(0, 7) == 0) begin
                    req[j] = 1'b1;
                    ra[7*j +: 7] = 7'($urandom);
                    rd[9*j +: 9] = 9'($urandom);
                end else if (req[j] && $urandom_range(0, 63) == 0) req[j] = 1'b0;
            end
            if (ev_start) begin
                cd   = ($urandom_range(0, 9) < 2) ? -1 : $urandom_range(0, 5);
                nack = ($urandom_range(0, 2) == 0);
            end
            if (rst) cd = -1;
            if (cd == 0) begin
                ed = 1'b1; ea = nack; cd = -1;
            end else begin
                ed = ($urandom_range(0, 49) == 0);
                ea = 1'($urandom);
                if (cd > 0) cd--;
            end
            eb = ($urandom_range(0, 5) == 0);
        end
        tick();
        rst = 1'b0; req = '0; ed = 1'b0; eb = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
